axi_lite_nport_arbiter: RTL and testbench

- Parametrised N-master to 1-slave AXI4-Lite arbiter; successor to the fixed two-slave-port (icache/LSU) arbiter in front of the core SRAM.
- Read (AR/R) and write (AW/W/B) paths are arbitrated independently, so one master's read and another's write can be in flight together.
- Each path holds its grant for one complete transaction. The AR/AW/W, R and B handshakes must all finish before the grant moves.
- Intended masters: icache, dcache, LSU uncached port, future DMA/debug.

---
 rtl/axi_lite_pkg.sv | 24 ++
 rtl/rr_picker.sv | 46 ++++
 rtl/axi_lite_nport_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_lite_nport_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite N-port arbiter.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_REQ  = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// One-hot winner selection among NUM_MST requesters.
// AXI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rr_picker
    import axi_lite_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int IDX_W   = idx_w(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_MST-1:0] gnt_o
);

`ifdef AXI_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        gnt_o = '0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end
`else
    logic found;
    int   idx;

    // Scan from ptr upward, wrapping; the first requester seen wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_MST; k++) begin
            idx = (int'(ptr_i) + k) % NUM_MST;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/axi_lite_nport_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter with independent read and write grants.
// AXI_ARB_FIXED_PRIO_EN: fixed lowest-index priority, no round-robin pointers.
module axi_lite_nport_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MST-1:0]            s_ar_valid,
    output logic [NUM_MST-1:0]            s_ar_ready,
    input  logic [NUM_MST*ADDR_W-1:0]     s_ar_addr,
    output logic [NUM_MST-1:0]            s_r_valid,
    input  logic [NUM_MST-1:0]            s_r_ready,
    output logic [1:0]                    s_r_resp,
    output logic [DATA_W-1:0]             s_r_data,
    input  logic [NUM_MST-1:0]            s_aw_valid,
    output logic [NUM_MST-1:0]            s_aw_ready,
    input  logic [NUM_MST*ADDR_W-1:0]     s_aw_addr,
    input  logic [NUM_MST-1:0]            s_w_valid,
    output logic [NUM_MST-1:0]            s_w_ready,
    input  logic [NUM_MST*DATA_W-1:0]     s_w_data,
    input  logic [NUM_MST*DATA_W/8-1:0]   s_w_strb,
    output logic [NUM_MST-1:0]            s_b_valid,
    input  logic [NUM_MST-1:0]            s_b_ready,
    output logic [1:0]                    s_b_resp,
    output logic                          m_ar_valid,
    input  logic                          m_ar_ready,
    output logic [ADDR_W-1:0]             m_ar_addr,
    input  logic                          m_r_valid,
    output logic                          m_r_ready,
    input  logic [1:0]                    m_r_resp,
    input  logic [DATA_W-1:0]             m_r_data,
    output logic                          m_aw_valid,
    input  logic                          m_aw_ready,
    output logic [ADDR_W-1:0]             m_aw_addr,
    output logic                          m_w_valid,
    input  logic                          m_w_ready,
    output logic [DATA_W-1:0]             m_w_data,
    output logic [DATA_W/8-1:0]           m_w_strb,
    input  logic                          m_b_valid,
    output logic                          m_b_ready,
    input  logic [1:0]                    m_b_resp
);

    localparam int IDX_W  = idx_w(NUM_MST);
    localparam int STRB_W = DATA_W / 8;

    typedef logic [NUM_MST-1:0] mask_t;
    typedef logic [IDX_W-1:0]   idx_t;

    function automatic idx_t oh2idx(input mask_t oh);
        idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (oh[i]) idx = idx_t'(i);
        end
        return idx;
    endfunction

    function automatic idx_t next_ptr(input mask_t oh);
        idx_t idx;
        idx = oh2idx(oh);
        return (idx == idx_t'(NUM_MST - 1)) ? '0 : idx + 1'b1;
    endfunction

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    mask_t     rd_gnt_q, rd_gnt_d, rd_pick;
    mask_t     wr_gnt_q, wr_gnt_d, wr_pick;
    logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
    idx_t      rd_ptr_q, wr_ptr_q;
    logic      rd_done, wr_done;

    assign rd_done = (rd_state_q == RD_DATA) && m_r_valid && m_r_ready;
    assign wr_done = (wr_state_q == WR_RESP) && m_b_valid && m_b_ready;

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign rd_ptr_q = '0;
    assign wr_ptr_q = '0;
`else
    idx_t rd_ptr_d, wr_ptr_d;
    assign rd_ptr_d = rd_done ? next_ptr(rd_gnt_q) : rd_ptr_q;
    assign wr_ptr_d = wr_done ? next_ptr(wr_gnt_q) : wr_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end
`endif

    rr_picker #(.NUM_MST(NUM_MST), .IDX_W(IDX_W)) u_rd_pick (
        .req_i (s_ar_valid),
        .ptr_i (rd_ptr_q),
        .gnt_o (rd_pick)
    );

    rr_picker #(.NUM_MST(NUM_MST), .IDX_W(IDX_W)) u_wr_pick (
        .req_i (s_aw_valid | s_w_valid),
        .ptr_i (wr_ptr_q),
        .gnt_o (wr_pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            rd_gnt_q   <= '0;
            wr_gnt_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        m_ar_valid = 1'b0;
        s_ar_ready = '0;
        m_r_ready  = 1'b0;
        s_r_valid  = '0;
        case (rd_state_q)
            RD_IDLE: begin
                if (|s_ar_valid) begin
                    rd_gnt_d   = rd_pick;
                    rd_state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                m_ar_valid = |(s_ar_valid & rd_gnt_q);
                s_ar_ready = m_ar_ready ? rd_gnt_q : '0;
                if (m_ar_valid && m_ar_ready) rd_state_d = RD_DATA;
            end
            RD_DATA: begin
                s_r_valid = m_r_valid ? rd_gnt_q : '0;
                m_r_ready = |(s_r_ready & rd_gnt_q);
                if (m_r_valid && m_r_ready) begin
                    rd_gnt_d   = '0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // AW and W complete independently; each is masked once its handshake is latched.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        m_aw_valid = 1'b0;
        m_w_valid  = 1'b0;
        s_aw_ready = '0;
        s_w_ready  = '0;
        m_b_ready  = 1'b0;
        s_b_valid  = '0;
        case (wr_state_q)
            WR_IDLE: begin
                if (|(s_aw_valid | s_w_valid)) begin
                    wr_gnt_d   = wr_pick;
                    wr_state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                m_aw_valid = !aw_done_q && |(s_aw_valid & wr_gnt_q);
                m_w_valid  = !w_done_q && |(s_w_valid & wr_gnt_q);
                s_aw_ready = (!aw_done_q && m_aw_ready) ? wr_gnt_q : '0;
                s_w_ready  = (!w_done_q && m_w_ready) ? wr_gnt_q : '0;
                aw_done_d  = aw_done_q | (m_aw_valid & m_aw_ready);
                w_done_d   = w_done_q | (m_w_valid & m_w_ready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                s_b_valid = m_b_valid ? wr_gnt_q : '0;
                m_b_ready = |(s_b_ready & wr_gnt_q);
                if (m_b_valid && m_b_ready) begin
                    wr_gnt_d   = '0;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        m_ar_addr = '0;
        m_aw_addr = '0;
        m_w_data  = '0;
        m_w_strb  = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (rd_gnt_q[i]) m_ar_addr = m_ar_addr | s_ar_addr[i*ADDR_W +: ADDR_W];
            if (wr_gnt_q[i]) begin
                m_aw_addr = m_aw_addr | s_aw_addr[i*ADDR_W +: ADDR_W];
                m_w_data  = m_w_data  | s_w_data[i*DATA_W +: DATA_W];
                m_w_strb  = m_w_strb  | s_w_strb[i*STRB_W +: STRB_W];
            end
        end
    end

    assign s_r_data = m_r_data;
    assign s_r_resp = m_r_resp;
    assign s_b_resp = m_b_resp;

endmodule

// File: tb/tb_axi_lite_nport_arbiter.sv
// Directed bench for the 4-master AXI4-Lite arbiter (vector table plus corner sequences).
module tb_axi_lite_nport_arbiter;
    import axi_lite_pkg::*;

    localparam int NM = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [NM-1:0]    s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [NM*AW-1:0] s_ar_addr, s_aw_addr;
    logic [1:0]       s_r_resp, s_b_resp;
    logic [DW-1:0]    s_r_data;
    logic [NM-1:0]    s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic [NM*DW-1:0] s_w_data;
    logic [NM*SW-1:0] s_w_strb;
    logic             m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [AW-1:0]    m_ar_addr, m_aw_addr;
    logic [1:0]       m_r_resp, m_b_resp;
    logic [DW-1:0]    m_r_data, m_w_data;
    logic             m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
    logic [SW-1:0]    m_w_strb;

    axi_lite_nport_arbiter #(.NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_resp(s_r_resp), .s_r_data(s_r_data),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_resp(m_r_resp), .m_r_data(m_r_data),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp)
    );

    always #5 clk = ~clk;

    logic [24:0] all_vr;
    assign all_vr = {m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready,
                     s_ar_ready, s_r_valid, s_aw_ready, s_w_ready, s_b_valid};

    int aw_hs = 0;
    int w_hs  = 0;
    always @(posedge clk) begin
        if (m_aw_valid && m_aw_ready) aw_hs++;
        if (m_w_valid && m_w_ready) w_hs++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NM-1:0] oh(input int i);
        logic [NM-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // One read transaction; the requester mask is held throughout, as a master with more work would.
    task automatic read_txn(input logic [NM-1:0] mask, input int exp, input logic [63:0] exp_addr,
                            input logic [63:0] rdata, input logic [1:0] rresp, input string tag);
        int n;
        s_ar_valid = mask;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
        s_r_ready  = '0;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_ar_valid && n < 8);
        chk({tag, "_grant_lat"}, 64'(n), 64'd1);
        chk({tag, "_ar_addr"}, m_ar_addr, exp_addr);
        chk({tag, "_ar_rdy_stall"}, 64'(s_ar_ready), 64'd0);
        m_ar_ready = 1'b1;
        #1;
        chk({tag, "_ar_rdy"}, 64'(s_ar_ready), 64'(oh(exp)));
        step();
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b1;
        m_r_data   = rdata;
        m_r_resp   = rresp;
        s_r_ready  = ~oh(exp);
        #1;
        chk({tag, "_r_valid"}, 64'(s_r_valid), 64'(oh(exp)));
        chk({tag, "_r_rdy_other"}, 64'(m_r_ready), 64'd0);
        chk({tag, "_r_data"}, s_r_data, rdata);
        chk({tag, "_r_resp"}, 64'(s_r_resp), 64'(rresp));
        step();
        s_r_ready = oh(exp);
        #1;
        chk({tag, "_r_rdy"}, 64'(m_r_ready), 64'd1);
        chk({tag, "_r_valid_hold"}, 64'(s_r_valid), 64'(oh(exp)));
        step();
        m_r_valid = 1'b0;
        s_r_ready = '0;
    endtask

    typedef struct {
        logic [NM-1:0] mask;
        int            exp_rr;
        int            exp_fp;
        logic [63:0]   data;
        logic [1:0]    resp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{4'b0011, 0, 0, 64'hDEAD_BEEF_0000_0000, RESP_OKAY};
        tbl[1]  = '{4'b0011, 1, 0, 64'hDEAD_BEEF_0000_0001, RESP_SLVERR};
        tbl[2]  = '{4'b0011, 0, 0, 64'hDEAD_BEEF_0000_0002, RESP_OKAY};
        tbl[3]  = '{4'b0011, 1, 0, 64'hDEAD_BEEF_0000_0003, RESP_OKAY};
        tbl[4]  = '{4'b1000, 3, 3, 64'hDEAD_BEEF_0000_0004, RESP_OKAY};
        tbl[5]  = '{4'b1001, 0, 0, 64'hDEAD_BEEF_0000_0005, RESP_SLVERR};
        tbl[6]  = '{4'b1001, 3, 0, 64'hDEAD_BEEF_0000_0006, RESP_OKAY};
        tbl[7]  = '{4'b0110, 1, 1, 64'hDEAD_BEEF_0000_0007, RESP_OKAY};
        tbl[8]  = '{4'b0110, 2, 1, 64'hDEAD_BEEF_0000_0008, RESP_OKAY};
        tbl[9]  = '{4'b0100, 2, 2, 64'hDEAD_BEEF_0000_0009, RESP_OKAY};
        tbl[10] = '{4'b0010, 1, 1, 64'hDEAD_BEEF_0000_000A, RESP_OKAY};

        s_ar_valid = '0; s_r_ready = '0; s_aw_valid = '0; s_w_valid = '0; s_b_ready = '0;
        s_ar_addr = '0; s_aw_addr = '0; s_w_data = '0; s_w_strb = '0;
        m_r_data = '0; m_r_resp = '0; m_b_resp = '0;

        // Reset with every input trying to provoke activity.
        rst_n = 1'b0;
        s_ar_valid = '1; s_aw_valid = '1; s_w_valid = '1; s_r_ready = '1; s_b_ready = '1;
        m_ar_ready = 1'b1; m_r_valid = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1; m_b_valid = 1'b1;
        step();
        step();
        chk("reset_outputs", 64'(all_vr), 64'd0);
        s_ar_valid = '0; s_aw_valid = '0; s_w_valid = '0; s_r_ready = '0; s_b_ready = '0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_outputs", 64'(all_vr), 64'd0);

        // Arbitration table: each master's address encodes its index.
        for (int i = 0; i < NM; i++) s_ar_addr[i*AW +: AW] = 64'h8000_0010 + 64'(i) * 64'h100;
        for (int k = 0; k < 11; k++) begin
            int e;
`ifdef AXI_ARB_FIXED_PRIO_EN
            e = tbl[k].exp_fp;
`else
            e = tbl[k].exp_rr;
`endif
            read_txn(tbl[k].mask, e, 64'h8000_0010 + 64'(e) * 64'h100,
                     tbl[k].data, tbl[k].resp, $sformatf("vec%0d", k));
        end
        s_ar_valid = '0;

        // Lone master 1 read.
        s_ar_addr[1*AW +: AW] = 64'h8000_0010;
        read_txn(4'b0010, 1, 64'h8000_0010, 64'h0000_0000_DEAD_BEEF, RESP_OKAY, "single_m1");
        s_ar_valid = '0;

        // Master 0 write: W presented one cycle ahead of AW.
        begin
            int n, aw0, w0;
            aw0 = aw_hs;
            w0  = w_hs;
            s_aw_addr[0 +: AW] = 64'h8000_0200;
            s_w_data[0 +: DW]  = 64'h1122_3344_5566_7788;
            s_w_strb[0 +: SW]  = 8'h0F;
            m_aw_ready = 1'b1;
            m_w_ready  = 1'b1;
            s_w_valid  = 4'b0001;
            n = 0;
            do begin
                step();
                n++;
            end while (!m_w_valid && n < 8);
            chk("wr_grant_lat", 64'(n), 64'd1);
            chk("wr_aw_not_yet", 64'(m_aw_valid), 64'd0);
            chk("wr_w_data", m_w_data, 64'h1122_3344_5566_7788);
            chk("wr_w_strb", 64'(m_w_strb), 64'h0F);
            chk("wr_w_ready", 64'(s_w_ready), 64'b0001);
            step();
            s_aw_valid = 4'b0001;
            #1;
            chk("wr_w_masked", 64'(m_w_valid), 64'd0);
            chk("wr_w_ready_done", 64'(s_w_ready), 64'd0);
            chk("wr_aw_valid", 64'(m_aw_valid), 64'd1);
            chk("wr_aw_addr", m_aw_addr, 64'h8000_0200);
            step();
            s_aw_valid = '0;
            s_w_valid  = '0;
            m_aw_ready = 1'b0;
            m_w_ready  = 1'b0;
            chk("wr_aw_hs_count", 64'(aw_hs - aw0), 64'd1);
            chk("wr_w_hs_count", 64'(w_hs - w0), 64'd1);
            m_b_valid = 1'b1;
            m_b_resp  = RESP_OKAY;
            s_b_ready = 4'b1110;
            #1;
            chk("wr_b_valid", 64'(s_b_valid), 64'b0001);
            chk("wr_b_rdy_other", 64'(m_b_ready), 64'd0);
            chk("wr_b_resp", 64'(s_b_resp), 64'(RESP_OKAY));
            step();
            s_b_ready = 4'b0001;
            #1;
            chk("wr_b_ready", 64'(m_b_ready), 64'd1);
            step();
            chk("wr_b_done", 64'(s_b_valid), 64'd0);
            m_b_valid = 1'b0;
            s_b_ready = '0;
        end

        // Master 0 reads while master 1 writes.
        s_ar_addr[0 +: AW]    = 64'h8000_1000;
        s_aw_addr[AW +: AW]   = 64'h8000_2000;
        s_w_data[DW +: DW]    = 64'hA5A5_5A5A_0F0F_F0F0;
        s_w_strb[SW +: SW]    = 8'hFF;
        s_ar_valid = 4'b0001;
        s_aw_valid = 4'b0010;
        s_w_valid  = 4'b0010;
        m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1;
        step();
        chk("cc_all_valid", 64'({m_ar_valid, m_aw_valid, m_w_valid}), 64'b111);
        chk("cc_ar_addr", m_ar_addr, 64'h8000_1000);
        chk("cc_aw_addr", m_aw_addr, 64'h8000_2000);
        chk("cc_w_data", m_w_data, 64'hA5A5_5A5A_0F0F_F0F0);
        chk("cc_readies", 64'({s_ar_ready, s_aw_ready, s_w_ready}), 64'({4'b0001, 4'b0010, 4'b0010}));
        step();
        s_ar_valid = '0; s_aw_valid = '0; s_w_valid = '0;
        m_ar_ready = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
        m_r_valid = 1'b1; m_r_data = 64'h0123_4567_89AB_CDEF; m_r_resp = RESP_OKAY;
        m_b_valid = 1'b1; m_b_resp = RESP_SLVERR;
        s_r_ready = 4'b0001; s_b_ready = 4'b0010;
        #1;
        chk("cc_r_valid", 64'(s_r_valid), 64'b0001);
        chk("cc_b_valid", 64'(s_b_valid), 64'b0010);
        chk("cc_b_resp", 64'(s_b_resp), 64'(RESP_SLVERR));
        chk("cc_m_readies", 64'({m_r_ready, m_b_ready}), 64'b11);
        step();
        chk("cc_both_done", 64'({s_r_valid, s_b_valid}), 64'd0);
        m_r_valid = 1'b0; m_b_valid = 1'b0; s_r_ready = '0; s_b_ready = '0;

        // Reset while master 2 sits in the data phase.
        s_ar_addr[2*AW +: AW] = 64'h8000_3000;
        s_ar_valid = 4'b0100;
        m_ar_ready = 1'b1;
        step();
        chk("rst_seq_ar_addr", m_ar_addr, 64'h8000_3000);
        step();
        s_ar_valid = '0;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b1;
        #1;
        chk("rst_seq_in_data", 64'(s_r_valid), 64'b0100);
        m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1; m_b_valid = 1'b1;
        rst_n = 1'b0;
        step();
        chk("rst_mid_outputs", 64'(all_vr), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_after_idle", 64'(all_vr), 64'd0);
        m_ar_ready = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0; m_r_valid = 1'b0;
        for (int i = 0; i < NM; i++) s_ar_addr[i*AW +: AW] = 64'h8000_0010 + 64'(i) * 64'h100;
        read_txn(4'b0110, 1, 64'h8000_0110, 64'h5555_AAAA_5555_AAAA, RESP_OKAY, "post_rst");
        s_ar_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
